// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Top-level control FSM for the AES encrypt datapath. It runs the HLS children
// AddRoundKey (ark), SubBytes (sb), ShiftRows (sr) and MixColumns (mc) one at a
// time over the shared statemt array. Because only one child is ever started,
// the statemt memory ports never see two masters.
//
// Round sequence for one encryption (NR rounds):
//   ARK(0), { SB, SR, MC, ARK(r) } for r = 1..NR-1, SB, SR, ARK(NR)
//   The final round skips MixColumns.
//
// Parameters
//   NR       number of AES rounds (10/12/14); must be 1..63 (6-bit round index)
//   TIMEOUT  max cycles per child invocation before abort; 0 disables it
//
// Ports
//   ap_clk                 clock, all logic on rising edge
//   ap_rst                 synchronous active-high reset
//   ap_start               start one encryption (sampled only in IDLE)
//   ap_done / ap_ready     one-cycle pulse at end of encryption or abort
//   ap_idle                high in IDLE while ap_start is low
//   ap_err                 qualifies ap_done: 1 = watchdog abort
//   round                  current round index 0..NR
//   ark_start / ark_done   AddRoundKey handshake, ark_n = round key index
//   sb_start  / sb_done    SubBytes handshake
//   sr_start  / sr_done    ShiftRows handshake
//   mc_start  / mc_done    MixColumns handshake
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       ap_start,
  output logic       ap_done,
  output logic       ap_idle,
  output logic       ap_ready,
  output logic       ap_err,
  output logic [5:0] round,
  output logic       ark_start,
  input  logic       ark_done,
  output logic [5:0] ark_n,
  output logic       sb_start,
  input  logic       sb_done,
  output logic       sr_start,
  input  logic       sr_done,
  output logic       mc_start,
  input  logic       mc_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARK  = 3'd1,
    S_SB   = 3'd2,
    S_SR   = 3'd3,
    S_MC   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // Watchdog is wide enough to hold TIMEOUT-1; it never needs to reach
  // TIMEOUT itself because the abort fires while it still reads TIMEOUT-1.
  localparam int               WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam logic [5:0]       NR_L    = 6'(NR);
  localparam bit               WD_EN   = (TIMEOUT != 0);

  state_t          state_reg;
  state_t          state_next;
  logic [5:0]      round_reg;
  logic [5:0]      round_next;
  logic [WD_W-1:0] wd_reg;

  logic            ark_start_reg;
  logic            sb_start_reg;
  logic            sr_start_reg;
  logic            mc_start_reg;
  logic            ap_done_reg;
  logic            ap_err_reg;

  logic            busy;
  logic            timeout_hit;

  assign busy = (state_reg == S_ARK) || (state_reg == S_SB) ||
                (state_reg == S_SR)  || (state_reg == S_MC);

  // Fires in the TIMEOUT-th cycle of a child invocation. A done in that same
  // cycle is checked first in the next-state logic, so done wins the tie.
  assign timeout_hit = WD_EN && busy && (wd_reg == WD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and round logic. Each child's done is only looked at in that
  // child's own state, so stray done pulses from idle children are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (ap_start) begin
          state_next = S_ARK;
          round_next = 6'd0;
        end
      end
      S_ARK: begin
        if (ark_done) begin
          if (round_reg == NR_L) begin
            state_next = S_DONE;
          end else begin
            round_next = round_reg + 6'd1;
            state_next = S_SB;
          end
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_SB: begin
        if (sb_done) begin
          state_next = S_SR;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_SR: begin
        if (sr_done) begin
          // Final round goes straight to the last AddRoundKey.
          state_next = (round_reg == NR_L) ? S_ARK : S_MC;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_MC: begin
        if (mc_done) begin
          state_next = S_ARK;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      // ap_start is deliberately ignored here; it is re-sampled in IDLE.
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs. The start/done outputs are decoded
  // from state_next so that, once registered, they equal a decode of the
  // current state: a start is high for the entire stay in its state and drops
  // in the cycle after its done was sampled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg     <= S_IDLE;
      round_reg     <= 6'd0;
      wd_reg        <= '0;
      ark_start_reg <= 1'b0;
      sb_start_reg  <= 1'b0;
      sr_start_reg  <= 1'b0;
      mc_start_reg  <= 1'b0;
      ap_done_reg   <= 1'b0;
      ap_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;

      if (state_next != state_reg) begin
        wd_reg <= '0;
      end else if (busy) begin
        wd_reg <= wd_reg + 1'b1;
      end

      ark_start_reg <= (state_next == S_ARK);
      sb_start_reg  <= (state_next == S_SB);
      sr_start_reg  <= (state_next == S_SR);
      mc_start_reg  <= (state_next == S_MC);
      ap_done_reg   <= (state_next == S_DONE) || (state_next == S_ERR);
      ap_err_reg    <= (state_next == S_ERR);
    end
  end

  assign ark_start = ark_start_reg;
  assign sb_start  = sb_start_reg;
  assign sr_start  = sr_start_reg;
  assign mc_start  = mc_start_reg;
  assign ap_done   = ap_done_reg;
  assign ap_ready  = ap_done_reg;
  assign ap_err    = ap_err_reg;
  assign ap_idle   = (state_reg == S_IDLE) && !ap_start;
  assign round     = round_reg;
  assign ark_n     = round_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for aes_round_sequencer. Three instances share one clock and reset:
//   u0: NR=10, TIMEOUT=1023   u1: NR=10, TIMEOUT=8   u2: NR=14, TIMEOUT=0
// Each child of each instance is a responder that raises done in the D-th
// cycle its start is high (optionally blocked, plus optional stray sb/mc
// done pulses while ARK runs). Child starts are logged as child*100+ark_n.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic ap_clk;
  logic ap_rst;
  logic [2:0] ap_start_v;
  wire  [2:0] done_w, idle_w, ready_w, err_w;
  wire  [3:0] st0, st1, st2;
  wire  [5:0] rnd0, rnd1, rnd2, arkn0, arkn1, arkn2;

  logic [3:0] st  [3];
  logic [3:0] dn  [3];
  logic [5:0] rnd [3];
  logic [5:0] akn [3];
  int         cnt [3][4];
  int         dly [3];
  logic [3:0] blk [3];
  logic       spur[3];
  logic [3:0] prev[3];
  int         logm[3][0:511];
  int         logn[3];
  int         nr_of[3];

  int checks;
  int errors;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  aes_round_sequencer #(.NR(10), .TIMEOUT(1023)) u0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start_v[0]),
    .ap_done(done_w[0]), .ap_idle(idle_w[0]), .ap_ready(ready_w[0]), .ap_err(err_w[0]),
    .round(rnd0), .ark_start(st0[0]), .ark_done(dn[0][0]), .ark_n(arkn0),
    .sb_start(st0[1]), .sb_done(dn[0][1]), .sr_start(st0[2]), .sr_done(dn[0][2]),
    .mc_start(st0[3]), .mc_done(dn[0][3]));

  aes_round_sequencer #(.NR(10), .TIMEOUT(8)) u1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start_v[1]),
    .ap_done(done_w[1]), .ap_idle(idle_w[1]), .ap_ready(ready_w[1]), .ap_err(err_w[1]),
    .round(rnd1), .ark_start(st1[0]), .ark_done(dn[1][0]), .ark_n(arkn1),
    .sb_start(st1[1]), .sb_done(dn[1][1]), .sr_start(st1[2]), .sr_done(dn[1][2]),
    .mc_start(st1[3]), .mc_done(dn[1][3]));

  aes_round_sequencer #(.NR(14), .TIMEOUT(0)) u2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start_v[2]),
    .ap_done(done_w[2]), .ap_idle(idle_w[2]), .ap_ready(ready_w[2]), .ap_err(err_w[2]),
    .round(rnd2), .ark_start(st2[0]), .ark_done(dn[2][0]), .ark_n(arkn2),
    .sb_start(st2[1]), .sb_done(dn[2][1]), .sr_start(st2[2]), .sr_done(dn[2][2]),
    .mc_start(st2[3]), .mc_done(dn[2][3]));

  assign st[0]  = st0;   assign st[1]  = st1;   assign st[2]  = st2;
  assign rnd[0] = rnd0;  assign rnd[1] = rnd1;  assign rnd[2] = rnd2;
  assign akn[0] = arkn0; assign akn[1] = arkn1; assign akn[2] = arkn2;

  // Child responders: done in the D-th cycle of start high.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        dn[k][c] = (st[k][c] && (cnt[k][c] == dly[k] - 1) && !blk[k][c]) ||
                   (spur[k] && st[k][0] && (c == 1 || c == 3));
      end
    end
  end

  always @(posedge ap_clk) begin
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++)
        cnt[k][c] <= st[k][c] ? cnt[k][c] + 1 : 0;
  end

  // Invocation log: one entry per rising start.
  initial begin
    for (int k = 0; k < 3; k++) begin
      logn[k] = 0;
      prev[k] = 4'b0;
    end
  end

  always @(negedge ap_clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (st[k][c] && !prev[k][c]) begin
          logm[k][logn[k] % 512] <= c * 100 + int'(akn[k]);
          logn[k] <= logn[k] + 1;
        end
      end
      prev[k] <= st[k];
    end
  end

  typedef struct {
    int         k;
    int         d;
    logic [3:0] blk;
    logic       spur;
    int         exp_lat;
    int         exp_err;
    int         exp_ark;
    int         exp_sb;
    int         exp_sr;
    int         exp_mc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int c;
    int base;
    int n;
    int cc[4];
    int e[0:127];
    int ne;
    int bad;
    @(negedge ap_clk);
    dly[v.k]  = v.d;
    blk[v.k]  = v.blk;
    spur[v.k] = v.spur;
    base = logn[v.k];
    ap_start_v[v.k] = 1'b1;
    c = 1;
    @(negedge ap_clk);
    c = 2;
    ap_start_v[v.k] = 1'b0;
    while (!done_w[v.k] && c < 3000) begin
      @(negedge ap_clk);
      c++;
    end
    chk($sformatf("v%0d done_seen", vi), int'(done_w[v.k]), 1);
    chk($sformatf("v%0d latency", vi), c, v.exp_lat);
    chk($sformatf("v%0d ap_err", vi), int'(err_w[v.k]), v.exp_err);
    chk($sformatf("v%0d ap_ready", vi), int'(ready_w[v.k]), 1);
    // Cycle after the done pulse: back in IDLE with all starts low.
    @(negedge ap_clk);
    chk($sformatf("v%0d post_starts", vi), int'(st[v.k]), 0);
    chk($sformatf("v%0d post_done", vi), int'(done_w[v.k]), 0);
    chk($sformatf("v%0d post_idle", vi), int'(idle_w[v.k]), 1);
    n = logn[v.k] - base;
    for (int i = 0; i < 4; i++) cc[i] = 0;
    for (int i = 0; i < n; i++) cc[logm[v.k][(base + i) % 512] / 100]++;
    chk($sformatf("v%0d ark_count", vi), cc[0], v.exp_ark);
    chk($sformatf("v%0d sb_count", vi), cc[1], v.exp_sb);
    chk($sformatf("v%0d sr_count", vi), cc[2], v.exp_sr);
    chk($sformatf("v%0d mc_count", vi), cc[3], v.exp_mc);
    if (v.exp_err == 0) begin
      ne = 0;
      for (int r = 0; r <= nr_of[v.k]; r++) begin
        e[ne++] = r;
        if (r < nr_of[v.k]) begin
          e[ne++] = 100 + r + 1;
          e[ne++] = 200 + r + 1;
          if (r < nr_of[v.k] - 1) e[ne++] = 300 + r + 1;
        end
      end
      bad = -1;
      for (int i = 0; i < ne && i < n; i++)
        if (bad < 0 && logm[v.k][(base + i) % 512] != e[i]) bad = i;
      if (bad < 0 && n != ne) bad = (n < ne) ? n : ne;
      chk($sformatf("v%0d order_first_bad_idx", vi), bad, -1);
    end
    $display("vec %0d dut=u%0d D=%0d lat=%0d err=%0d invocations=%0d",
             vi, v.k, v.d, c, int'(err_w[v.k]), n);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    int idle_seen;
    checks = 0;
    errors = 0;
    nr_of[0] = 10; nr_of[1] = 10; nr_of[2] = 14;
    for (int k = 0; k < 3; k++) begin
      dly[k] = 3; blk[k] = 4'b0; spur[k] = 1'b0;
    end
    //          k  D  blk      spur lat  err ark sb  sr  mc
    vecs[0] = '{0, 3, 4'b0000, 0,   122, 0,  11, 10, 10, 9};
    vecs[1] = '{0, 3, 4'b0000, 1,   122, 0,  11, 10, 10, 9};
    vecs[2] = '{0, 1, 4'b0000, 0,   42,  0,  11, 10, 10, 9};
    vecs[3] = '{0, 5, 4'b0000, 0,   202, 0,  11, 10, 10, 9};
    vecs[4] = '{2, 2, 4'b0000, 0,   114, 0,  15, 14, 14, 13};
    vecs[5] = '{1, 8, 4'b0000, 0,   322, 0,  11, 10, 10, 9};
    vecs[6] = '{1, 3, 4'b0010, 0,   13,  1,  1,  1,  0,  0};
    vecs[7] = '{1, 3, 4'b0001, 0,   10,  1,  1,  0,  0,  0};

    ap_rst = 1'b1;
    ap_start_v = 3'b000;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;

    // Reset state.
    chk("rst ap_done", int'(done_w[0]), 0);
    chk("rst ap_ready", int'(ready_w[0]), 0);
    chk("rst ap_err", int'(err_w[0]), 0);
    chk("rst starts", int'(st[0]), 0);
    chk("rst round", int'(rnd[0]), 0);
    chk("rst ap_idle", int'(idle_w[0]), 1);
    ap_start_v[0] = 1'b1;
    #1;
    chk("idle_with_start", int'(idle_w[0]), 0);
    ap_start_v[0] = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while MC of round 5 is running.
    @(negedge ap_clk);
    dly[0] = 3; blk[0] = 4'b0; spur[0] = 1'b0;
    ap_start_v[0] = 1'b1;
    @(negedge ap_clk);
    ap_start_v[0] = 1'b0;
    c = 0;
    while (!(st[0][3] && rnd[0] == 6'd5) && c < 500) begin
      @(negedge ap_clk);
      c++;
    end
    chk("midrst reached_mc5", int'(st[0][3] && rnd[0] == 6'd5), 1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("midrst round", int'(rnd[0]), 0);
    chk("midrst starts", int'(st[0]), 0);
    chk("midrst ap_idle", int'(idle_w[0]), 1);
    chk("midrst ap_done", int'(done_w[0]), 0);
    $display("midrst reset in MC round 5 after %0d cycles", c);
    run_vec(8, vecs[0]);

    // ap_start held high: back-to-back encryptions.
    @(negedge ap_clk);
    dly[0] = 1;
    ap_start_v[0] = 1'b1;
    idle_seen = 0;
    c = 1;
    @(negedge ap_clk);
    c = 2;
    while (!done_w[0] && c < 3000) begin
      if (idle_w[0]) idle_seen = 1;
      @(negedge ap_clk);
      c++;
    end
    chk("b2b first_lat", c, 42);
    @(negedge ap_clk);
    c++;
    if (idle_w[0]) idle_seen = 1;
    chk("b2b gap_ark_start", int'(st[0][0]), 0);
    @(negedge ap_clk);
    c++;
    chk("b2b second_ark_start", int'(st[0][0]), 1);
    chk("b2b second_ark_n", int'(akn[0]), 0);
    ap_start_v[0] = 1'b0;
    while (!done_w[0] && c < 3000) begin
      if (idle_w[0]) idle_seen = 1;
      @(negedge ap_clk);
      c++;
    end
    chk("b2b second_lat", c, 84);
    chk("b2b idle_never_high", idle_seen, 0);
    @(negedge ap_clk);
    chk("b2b final_idle", int'(idle_w[0]), 1);
    $display("b2b second done at cycle %0d idle_seen=%0d", c, idle_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
